// File: rtl/sd_clk_pkg.sv
// Shared state encoding and default speed/burst constants for the SD card-clock controller.
package sd_clk_pkg;

    typedef enum logic [1:0] {
        PWRUP   = 2'd0,
        RUN     = 2'd1,
        SWITCH  = 2'd2,
        STOPPED = 2'd3
    } sd_clk_state_t;

    localparam int DEF_INIT_CKSPD = 252;
    localparam int DEF_NINIT      = 80;
    localparam int CKSPD_FASTEST  = 0;

endpackage

// File: rtl/sd_clk_cnt.sv
// Qualifies sdckgen strobes as delivered card clocks and keeps a wrapping count of them.
// Combinational qualifier, count registered one cycle later; no backpressure.
module sd_clk_cnt #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_ckstb,
    input  logic         i_shutdown,
    output logic         o_counted,
    output logic [W-1:0] o_count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign o_counted = i_ckstb && !i_shutdown;
    assign o_count   = count_q;

    always_comb begin
        count_d = count_q;
        if (o_counted) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sd_clk_ctrl.sv
// Sequences sdckgen config: power-up burst, handshaked speed changes, idle/stall clock gating.
// Config outputs are registered; o_req_ready is combinational and drops in RUN while the FIFO stalls.
module sd_clk_ctrl
    import sd_clk_pkg::*;
#(
    parameter int                  LGMAXDIV   = 8,
    parameter logic [LGMAXDIV-1:0] INIT_CKSPD = LGMAXDIV'(DEF_INIT_CKSPD),
    parameter int                  NINIT      = DEF_NINIT,
    parameter int                  LGIDLE     = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_req_valid,
    input  logic [LGMAXDIV-1:0] i_req_ckspd,
    input  logic                i_req_clk90,
    output logic                o_req_ready,
    output logic                o_req_ack,
    input  logic                i_auto_stop,
    input  logic [LGIDLE-1:0]   i_idle_clocks,
    input  logic                i_cmd_busy,
    input  logic                i_data_busy,
    input  logic                i_fifo_stall,
    input  logic                i_ckstb,
    input  logic [LGMAXDIV-1:0] i_ckspd,
    output logic [LGMAXDIV-1:0] o_cfg_ckspd,
    output logic                o_cfg_clk90,
    output logic                o_cfg_shutdown,
    output logic                o_init_done,
    output logic                o_clk_stopped,
    output logic [15:0]         o_clk_count
);

    sd_clk_state_t       state_q, state_d;
    logic [LGMAXDIV-1:0] ckspd_q, ckspd_d;
    logic                clk90_q, clk90_d;
    logic                init_done_q, init_done_d;
    logic                ack_q, ack_d;
    logic                matched_q, matched_d;
    logic [LGIDLE-1:0]   idle_q, idle_d;

    logic        counted;
    logic        shutdown;
    logic        busy;
    logic        accept;
    logic [15:0] clk_count;

    assign shutdown    = (state_q == STOPPED);
    assign busy        = i_cmd_busy || i_data_busy;
    assign o_req_ready = ((state_q == RUN) && !i_fifo_stall) || (state_q == STOPPED);
    assign accept      = i_req_valid && o_req_ready;

    sd_clk_cnt #(.W(16)) u_cnt (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_ckstb    (i_ckstb),
        .i_shutdown (shutdown),
        .o_counted  (counted),
        .o_count    (clk_count)
    );

    always_comb begin
        state_d     = state_q;
        ckspd_d     = ckspd_q;
        clk90_d     = clk90_q;
        init_done_d = init_done_q;
        ack_d       = 1'b0;
        matched_d   = matched_q;
        idle_d      = idle_q;

        case (state_q)
            PWRUP: begin
                // The card-clock counter starts at zero on reset, so it doubles as the burst counter.
                if (counted && (clk_count == 16'(NINIT - 1))) begin
                    init_done_d = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (busy || !i_auto_stop) begin
                    idle_d = '0;
                end else if (counted && (idle_q != '1)) begin
                    idle_d = idle_q + LGIDLE'(1);
                end

                if (i_fifo_stall) begin
                    state_d = STOPPED;
                end else if (accept) begin
                    ckspd_d   = i_req_ckspd;
                    clk90_d   = i_req_clk90;
                    matched_d = 1'b0;
                    state_d   = SWITCH;
                end else if (i_auto_stop && !busy && (idle_d >= i_idle_clocks)) begin
                    state_d = STOPPED;
                end
            end
            SWITCH: begin
                // Echo match arms the ack; a strictly later delivered clock confirms it.
                if (!matched_q) begin
                    if (i_ckspd == ckspd_q) begin
                        matched_d = 1'b1;
                    end
                end else if (counted) begin
                    matched_d = 1'b0;
                    ack_d     = 1'b1;
                    state_d   = RUN;
                end
            end
            STOPPED: begin
                idle_d = '0;
                if (accept) begin
                    ckspd_d = i_req_ckspd;
                    clk90_d = i_req_clk90;
                    ack_d   = 1'b1;
                end
                if (!i_fifo_stall && (busy || !i_auto_stop)) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = PWRUP;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= PWRUP;
            ckspd_q     <= INIT_CKSPD;
            clk90_q     <= 1'b0;
            init_done_q <= 1'b0;
            ack_q       <= 1'b0;
            matched_q   <= 1'b0;
            idle_q      <= '0;
        end else begin
            state_q     <= state_d;
            ckspd_q     <= ckspd_d;
            clk90_q     <= clk90_d;
            init_done_q <= init_done_d;
            ack_q       <= ack_d;
            matched_q   <= matched_d;
            idle_q      <= idle_d;
        end
    end

    assign o_cfg_ckspd    = ckspd_q;
    assign o_cfg_clk90    = clk90_q || (ckspd_q == LGMAXDIV'(CKSPD_FASTEST));
    assign o_cfg_shutdown = shutdown;
    assign o_clk_stopped  = shutdown;
    assign o_init_done    = init_done_q;
    assign o_req_ack      = ack_q;
    assign o_clk_count    = clk_count;

endmodule

// File: tb/tb_sd_clk_ctrl.sv
// Directed bench for sd_clk_ctrl: power-up burst, speed change, auto-stop, stall handling, reset.
module tb_sd_clk_ctrl;

    logic       i_clk;
    logic       i_reset;
    logic       i_req_valid;
    logic [7:0] i_req_ckspd;
    logic       i_req_clk90;
    logic       o_req_ready;
    logic       o_req_ack;
    logic       i_auto_stop;
    logic [3:0] i_idle_clocks;
    logic       i_cmd_busy;
    logic       i_data_busy;
    logic       i_fifo_stall;
    logic       i_ckstb;
    logic [7:0] i_ckspd;
    logic [7:0] o_cfg_ckspd;
    logic       o_cfg_clk90;
    logic       o_cfg_shutdown;
    logic       o_init_done;
    logic       o_clk_stopped;
    logic [15:0] o_clk_count;

    int total   = 0;
    int bad     = 0;
    int ack_cnt = 0;
    int spd_bad = 0;

    sd_clk_ctrl dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_req_valid    (i_req_valid),
        .i_req_ckspd    (i_req_ckspd),
        .i_req_clk90    (i_req_clk90),
        .o_req_ready    (o_req_ready),
        .o_req_ack      (o_req_ack),
        .i_auto_stop    (i_auto_stop),
        .i_idle_clocks  (i_idle_clocks),
        .i_cmd_busy     (i_cmd_busy),
        .i_data_busy    (i_data_busy),
        .i_fifo_stall   (i_fifo_stall),
        .i_ckstb        (i_ckstb),
        .i_ckspd        (i_ckspd),
        .o_cfg_ckspd    (o_cfg_ckspd),
        .o_cfg_clk90    (o_cfg_clk90),
        .o_cfg_shutdown (o_cfg_shutdown),
        .o_init_done    (o_init_done),
        .o_clk_stopped  (o_clk_stopped),
        .o_clk_count    (o_clk_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_req_ack === 1'b1) ack_cnt = ack_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic strobe();
        i_ckstb = 1'b1;
        tick();
        i_ckstb = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic pwrup_burst(input string tag, input bit with_noise);
        spd_bad = 0;
        for (int i = 1; i <= 80; i++) begin
            if (with_noise && i == 5) begin
                i_req_valid  = 1'b1;
                i_req_ckspd  = 8'd5;
                i_fifo_stall = 1'b1;
            end
            if (with_noise && i == 10) check({tag, "_ready_pwrup"}, o_req_ready, 0);
            if (with_noise && i == 20) begin
                i_req_valid  = 1'b0;
                i_fifo_stall = 1'b0;
            end
            i_ckstb = 1'b1;
            tick();
            if (i == 79) check({tag, "_init_early"}, o_init_done, 0);
            if (i == 80) check({tag, "_init_done"}, o_init_done, 1);
            if (o_cfg_ckspd != 8'd252) spd_bad = spd_bad + 1;
            i_ckstb = 1'b0;
            tick();
            tick();
            tick();
        end
        check({tag, "_ckspd_steady"}, spd_bad, 0);
        check({tag, "_count80"}, o_clk_count, 80);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ckspd"}, o_cfg_ckspd, 252);
        check({tag, "_clk90"}, o_cfg_clk90, 0);
        check({tag, "_shutdown"}, o_cfg_shutdown, 0);
        check({tag, "_init"}, o_init_done, 0);
        check({tag, "_stopped"}, o_clk_stopped, 0);
        check({tag, "_ready"}, o_req_ready, 0);
        check({tag, "_ack"}, o_req_ack, 0);
        check({tag, "_count"}, o_clk_count, 0);
    endtask

    initial begin
        i_reset       = 1'b1;
        i_req_valid   = 1'b0;
        i_req_ckspd   = 8'd0;
        i_req_clk90   = 1'b0;
        i_auto_stop   = 1'b0;
        i_idle_clocks = 4'd0;
        i_cmd_busy    = 1'b0;
        i_data_busy   = 1'b0;
        i_fifo_stall  = 1'b0;
        i_ckstb       = 1'b0;
        i_ckspd       = 8'd252;
        tick();
        tick();
        check_reset_state("rst1");
        i_reset = 1'b0;

        // Power-up burst with a request and a stall presented that must be ignored
        pwrup_burst("pwr1", 1'b1);
        check("run_ready", o_req_ready, 1);

        // Speed change to the fastest code: clk90 forced, ack one strobe after the echo
        i_req_valid = 1'b1;
        i_req_ckspd = 8'd0;
        i_req_clk90 = 1'b0;
        #1;
        check("req_ready", o_req_ready, 1);
        tick();
        i_req_valid = 1'b0;
        check("sw_ckspd", o_cfg_ckspd, 0);
        check("sw_clk90_forced", o_cfg_clk90, 1);
        check("sw_ready", o_req_ready, 0);
        strobe();
        check("sw_no_ack_before_echo", ack_cnt, 0);
        i_ckspd = 8'd0;
        tick();
        check("sw_no_ack_at_echo", ack_cnt, 0);
        i_ckstb = 1'b1;
        tick();
        check("sw_ack_pulse", o_req_ack, 1);
        i_ckstb = 1'b0;
        tick();
        check("sw_ack_drop", o_req_ack, 0);
        check("sw_ack_once", ack_cnt, 1);
        check("sw_count", o_clk_count, 82);

        // Auto-stop after three idle strobes, restart on command busy
        i_auto_stop   = 1'b1;
        i_idle_clocks = 4'd3;
        strobe();
        strobe();
        check("idle_not_yet", o_cfg_shutdown, 0);
        i_ckstb = 1'b1;
        tick();
        check("idle_shutdown", o_cfg_shutdown, 1);
        check("idle_stopped", o_clk_stopped, 1);
        i_ckstb = 1'b0;
        tick();
        check("idle_count", o_clk_count, 85);
        strobe();
        check("idle_no_count_stopped", o_clk_count, 85);
        i_cmd_busy = 1'b1;
        tick();
        check("busy_restart", o_cfg_shutdown, 0);

        // Zero idle threshold stops on the first idle cycle
        i_cmd_busy    = 1'b0;
        i_idle_clocks = 4'd0;
        tick();
        check("idle0_stop", o_cfg_shutdown, 1);
        i_auto_stop = 1'b0;
        tick();
        check("idle0_leave", o_cfg_shutdown, 0);

        // Stall and request in the same RUN cycle: stall wins, request taken in STOPPED
        i_fifo_stall = 1'b1;
        i_req_valid  = 1'b1;
        i_req_ckspd  = 8'd4;
        i_req_clk90  = 1'b1;
        #1;
        check("stall_ready_low", o_req_ready, 0);
        tick();
        check("stall_shutdown", o_cfg_shutdown, 1);
        check("stall_req_not_taken", o_cfg_ckspd, 0);
        tick();
        check("stop_req_ckspd", o_cfg_ckspd, 4);
        check("stop_req_clk90", o_cfg_clk90, 1);
        check("stop_req_ack", o_req_ack, 1);
        i_req_valid = 1'b0;
        tick();
        check("stop_ack_drop", o_req_ack, 0);
        check("stop_ack_cnt", ack_cnt, 2);
        check("stop_still_stalled", o_cfg_shutdown, 1);
        i_fifo_stall = 1'b0;
        tick();
        check("stall_release", o_cfg_shutdown, 0);

        // Stall during SWITCH is deferred until after the ack
        i_req_valid = 1'b1;
        i_req_ckspd = 8'd2;
        i_req_clk90 = 1'b0;
        tick();
        i_req_valid  = 1'b0;
        i_fifo_stall = 1'b1;
        check("sw2_ckspd", o_cfg_ckspd, 2);
        check("sw2_clk90", o_cfg_clk90, 0);
        check("sw2_ready", o_req_ready, 0);
        tick();
        check("sw2_stall_deferred", o_cfg_shutdown, 0);
        strobe();
        check("sw2_count", o_clk_count, 86);
        i_ckspd = 8'd2;
        tick();
        i_ckstb = 1'b1;
        tick();
        check("sw2_ack", o_req_ack, 1);
        check("sw2_run_before_stop", o_cfg_shutdown, 0);
        i_ckstb = 1'b0;
        tick();
        check("sw2_then_stop", o_cfg_shutdown, 1);
        check("sw2_ack_cnt", ack_cnt, 3);
        strobe();
        strobe();
        check("sw2_no_count_stopped", o_clk_count, 87);
        i_fifo_stall = 1'b0;
        tick();
        check("sw2_release", o_cfg_shutdown, 0);

        // Run the count up to 500, then reset mid-operation and repeat the burst
        i_ckstb = 1'b1;
        repeat (413) tick();
        i_ckstb = 1'b0;
        check("count500", o_clk_count, 500);
        i_reset = 1'b1;
        tick();
        check_reset_state("rst2");
        i_reset = 1'b0;
        pwrup_burst("pwr2", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
